fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage feeding the decode side of the five-stage pipeline. Issues word-aligned requests to instruction memory, buffers returned instructions with their PCs in a small prefetch FIFO, and presents one {pc, instr} pair per cycle to decode.
- Decode consumption is gated by the hazard unit's `stall` signal, which is the same signal that zeroes the control mask.
- EX-stage branch/jump redirects flush the FIFO and discard any stale in-flight memory response.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 2: prefetch FIFO entries; must be ≥ 2.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-low reset. Asserted when 0. Clears all state immediately.
- `imem_req`  out  1: fetch request. Memory always accepts in the same cycle.
- `imem_addr`  out  32: fetch address; bits [1:0] always 0.
- `imem_rvalid`  in  1: response valid. Arrives ≥1 cycle after the accepted request.
- `imem_rdata`  in  32: instruction word, valid with `imem_rvalid`.
- `redirect`  in  1: branch taken or jump from EX; single-cycle pulse.
- `redirect_pc`  in  32: target address; bits [1:0] are ignored and forced to 0.
- `stall`  in  1: decode cannot accept this cycle. Head entry is held.
- `if_valid`  out  1: `if_pc`/`if_instr` hold a live instruction.
- `if_pc`  out  32: PC of the head entry.
- `if_instr`  out  32: instruction of the head entry. Reads NOP 32'h0000_0013 when `if_valid`=0.

## Operation
- `pc_q` holds the next address to fetch. At most one request is outstanding.
- FSM states: `S_REQ`, `S_WAIT`, `S_DRAIN`, `S_FULL`.
- `S_REQ`:
  - `imem_req` = !`redirect`; `imem_addr` = `pc_q`.
  - No redirect → go to `S_WAIT`.
  - Redirect → `pc_q` ← `redirect_pc`; stay in `S_REQ`. No request is issued that cycle.
- `S_WAIT`:
  - On `imem_rvalid` with no redirect: push {`pc_q`, `imem_rdata`} and set `pc_q` ← `pc_q`+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - After that push, go to `S_REQ` if post-cycle occupancy < `DEPTH`, else `S_FULL`.
- Redirect in `S_WAIT`:
  - With `imem_rvalid` in the same cycle: discard the response, `pc_q` ← target, go to `S_REQ`.
  - Without `imem_rvalid`: `pc_q` ← target, go to `S_DRAIN`.
- `S_DRAIN`:
  - `imem_rvalid` → discard the response, go to `S_REQ`.
  - A further redirect → update `pc_q`, stay in `S_DRAIN`.
- `S_FULL`:
  - A pop this cycle (`if_valid` && !`stall`) → go to `S_REQ`.
  - Redirect → `pc_q` ← target, go to `S_REQ`.
- `imem_rvalid` in `S_REQ` or `S_FULL` is ignored.
- Pop: head advances when `if_valid` && !`stall`. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Redirect clears all FIFO entries in that cycle. It overrides any same-cycle push or pop.
- FIFO pointers wrap modulo `DEPTH`. Occupancy counter width is $clog2(`DEPTH`+1).

## Timing
- Reset values: state `S_REQ`, `pc_q` = `RESET_PC`, FIFO empty, `if_valid`=0, `if_pc`=0, `if_instr`=NOP. `imem_req` is 1 in the first cycle after reset release.
- Minimum latency:
  - Request in cycle N, `imem_rvalid` in N+1, `if_valid`=1 in N+2.
  - Next request is issued in N+2.
  - Steady state is one instruction per two cycles with single-latency memory.
- Redirect in cycle R: `if_valid`=0 from R+1. First request to the target is issued in R+1 (from `S_REQ`/`S_WAIT`/`S_FULL`), or one cycle after the stale response (from `S_DRAIN`).
- Outputs `if_*` come straight from FIFO storage and head pointer. There is no combinational path from `stall` or `redirect` to `if_*`.
- Reset asserted mid-operation clears immediately. Any response to a pre-reset request is ignored, because state after reset is `S_REQ`.

## Structure
- Package `fetch_pkg`:
  - enum `fetch_state_t`.
  - `localparam NOP_INSTR` = 32'h0000_0013.
  - packed struct `fetch_entry_t` {pc[31:0], instr[31:0]}.
- Sub-module `fetch_fifo`:
  - Parameterised on `DEPTH`, storing `fetch_entry_t`.
  - Ports: push, pop, flush, head, count.
  - Same clk and async active-low reset.
- FSM and PC logic live in `fetch_unit`.

## Test plan
- **Reset release, 1-cycle memory, `stall`=0:** addresses 0, 4, 8 are requested in cycles 0, 2, 4; `if_pc`=0/4/8 is valid in cycles 2, 4, 6.
- **`stall` held high for 10 cycles:** the FIFO fills to 2 and the FSM reaches `S_FULL` with `imem_req` low. Releasing `stall` pops 0, then 4, and fetching resumes at 8.
- **`redirect` to 32'h0000_0103 while a request is outstanding with 3-cycle memory latency:** the stale word is dropped and never appears on `if_*`. The next `imem_addr` is 32'h0000_0100.
- **`redirect` in the same cycle as `imem_rvalid` and a pop:** FIFO empty, `if_valid`=0 next cycle, and the following request targets `redirect_pc`.
- **`RESET_PC`=32'hFFFF_FFF8:** fetches 32'hFFFF_FFF8, then 32'hFFFF_FFFC, then wraps to 0.
- **Async reset asserted mid-`S_DRAIN` with a pending `imem_rvalid`:** outputs return to reset values without waiting for a clock. The late response is ignored, and the first post-reset request is to `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_FULL  = 2'd3
  } fetch_state_t;

  // addi x0, x0, 0 -- shown to decode whenever nothing live is buffered
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO holding {pc, instr} pairs; head is read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Pointers wrap modulo DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Entry storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg] <= push_entry;
  end

  // Pointer and occupancy tracking; flush wins over any push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, prefetch FIFO, redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int          CNT_W      = $clog2(DEPTH + 1);
  localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

  fetch_state_t     state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] post_count;
  fetch_entry_t     fifo_head;
  fetch_entry_t     push_entry;
  logic             push;
  logic             pop;

  // A response is kept only when it answers the live request and no redirect kills it
  assign push       = (state_reg == S_WAIT) && imem_rvalid && !redirect;
  assign pop        = if_valid && !stall;
  assign push_entry = {pc_reg, imem_rdata};
  // Occupancy after a push in S_WAIT, accounting for a same-cycle pop
  assign post_count = fifo_count + CNT_W'(1) - CNT_W'(pop);

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // State and fetch-PC registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_REQ;
      pc_reg    <= RESET_ADDR;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next state and next fetch PC; a redirect always retargets pc
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (redirect)  pc_next = redirect_pc & 32'hFFFF_FFFC;
    else if (push) pc_next = pc_reg + 32'd4;
    case (state_reg)
      S_REQ:   if (!redirect) state_next = S_WAIT;
      S_WAIT: begin
        if (redirect)         state_next = imem_rvalid ? S_REQ : S_DRAIN;
        else if (imem_rvalid) state_next = (post_count < CNT_W'(DEPTH)) ? S_REQ : S_FULL;
      end
      S_DRAIN: if (imem_rvalid) state_next = S_REQ;
      S_FULL:  if (pop || redirect) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
  end

  // Outputs: request from state, decode view straight from FIFO head
  always_comb begin
    imem_req  = (state_reg == S_REQ) && !redirect;
    imem_addr = pc_reg;
    if_valid  = (fifo_count != '0);
    if_pc     = if_valid ? fifo_head.pc : 32'h0;
    if_instr  = if_valid ? fifo_head.instr : NOP_INSTR;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs a queue model.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req, imem_req_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        if_valid, if_valid_w;
  logic [31:0] if_pc, if_pc_w, if_instr, if_instr_w;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  // Second instance only to observe PC wraparound from a high reset address
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .reset(reset), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .if_valid(if_valid_w),
    .if_pc(if_pc_w), .if_instr(if_instr_w)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: buffered pairs, whether a request is in flight, whether it is stale, next pc
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  bit          m_outst, m_stale;
  logic [31:0] m_pc;

  // Memory environment
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_left;
  int          lat_fixed = 1;
  bit          rand_mode = 0;
  bit          spurious_en = 0;
  bit          s_req;
  logic [31:0] s_addr;
  bit          exp_req;

  bit          t_req[64], t_valid[64], t_req_w[64];
  logic [31:0] t_addr[64], t_pc[64], t_instr[64], t_addr_w[64], t_pc_w[64];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_outst = 0;
    m_stale = 0;
    m_pc = 32'h0;
  endtask

  // Advance the model by one clock using the inputs present during the ending cycle
  task automatic model_update();
    bit req_now, resp;
    req_now = !m_outst && (mq.size() < DEPTH) && !redirect;
    resp = m_outst && imem_rvalid;
    if (redirect) begin
      mq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      if (resp) begin
        m_outst = 0;
        m_stale = 0;
      end else if (m_outst) begin
        m_stale = 1;
      end
    end else begin
      if (mq.size() > 0 && !stall) begin
        if (!rand_mode) $display("decode takes pc=%h instr=%h", mq[0].pc, mq[0].instr);
        void'(mq.pop_front());
      end
      if (resp) begin
        if (!m_stale) begin
          mq.push_back({m_pc, imem_rdata});
          m_pc = m_pc + 32'd4;
        end
        m_outst = 0;
        m_stale = 0;
      end
    end
    if (req_now) m_outst = 1;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    if (mem_pend && imem_rvalid) mem_pend = 0;
    if (s_req) begin
      mem_pend = 1;
      mem_addr = s_addr;
      mem_left = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
    end
    cyc++;
    #1;
    redirect = 1'b0;
    if (mem_pend) begin
      mem_left--;
      imem_rvalid = (mem_left == 0);
      imem_rdata  = imem_rvalid ? mem_f(mem_addr) : $urandom();
    end else begin
      imem_rvalid = spurious_en && ($urandom_range(0, 6) == 0);
      imem_rdata  = JUNK;
    end
    if (rand_mode) begin
      stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 12) == 0) begin
        redirect = 1'b1;
        redirect_pc = $urandom();
      end
    end
  endtask

  task automatic do_reset(input bit stale_rv);
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    imem_rvalid = stale_rv;
    imem_rdata = JUNK;
    model_reset();
    mem_pend = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      s_req = 0;
    end else begin
      s_req  = imem_req;
      s_addr = imem_addr;
      if (cyc < 64) begin
        t_req[cyc] = imem_req;     t_addr[cyc] = imem_addr;
        t_valid[cyc] = if_valid;   t_pc[cyc] = if_pc;   t_instr[cyc] = if_instr;
        t_req_w[cyc] = imem_req_w; t_addr_w[cyc] = imem_addr_w; t_pc_w[cyc] = if_pc_w;
      end
      chk1("if_valid", if_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("if_pc", if_pc, mq[0].pc);
        chk("if_instr", if_instr, mq[0].instr);
      end else begin
        chk("if_pc_idle", if_pc, 32'h0);
        chk("if_instr_idle", if_instr, NOP);
      end
      exp_req = !m_outst && (mq.size() < DEPTH) && !redirect;
      chk1("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
    end
  end

  initial begin
    // Straight-line fetch, 1-cycle memory, no stall; also the wraparound instance
    lat_fixed = 1;
    do_reset(0);
    repeat (8) step();
    chk1("p1_req0", t_req[0], 1'b1);    chk("p1_addr0", t_addr[0], 32'h0);
    chk1("p1_req1", t_req[1], 1'b0);
    chk1("p1_req2", t_req[2], 1'b1);    chk("p1_addr2", t_addr[2], 32'h4);
    chk1("p1_req4", t_req[4], 1'b1);    chk("p1_addr4", t_addr[4], 32'h8);
    chk1("p1_valid1", t_valid[1], 1'b0);
    chk1("p1_valid2", t_valid[2], 1'b1); chk("p1_pc2", t_pc[2], 32'h0);
    chk("p1_instr2", t_instr[2], 32'h1357_9BDF);
    chk("p1_pc4", t_pc[4], 32'h4);      chk("p1_pc6", t_pc[6], 32'h8);
    chk1("wrap_req0", t_req_w[0], 1'b1);
    chk("wrap_addr0", t_addr_w[0], 32'hFFFF_FFF8);
    chk("wrap_addr2", t_addr_w[2], 32'hFFFF_FFFC);
    chk("wrap_addr4", t_addr_w[4], 32'h0);
    chk("wrap_pc6", t_pc_w[6], 32'h0);

    // Stall for 10 cycles: FIFO fills, requests stop, then drain 0 and 4 and resume at 8
    do_reset(0);
    stall = 1'b1;
    repeat (10) step();
    stall = 1'b0;
    repeat (4) step();
    chk1("st_req9", t_req[9], 1'b0);
    chk1("st_valid9", t_valid[9], 1'b1); chk("st_pc9", t_pc[9], 32'h0);
    chk("st_pc10", t_pc[10], 32'h0);   chk("st_pc11", t_pc[11], 32'h4);
    chk1("st_req11", t_req[11], 1'b1); chk("st_addr11", t_addr[11], 32'h8);

    // Redirect with a request outstanding on 3-cycle memory: stale word dropped
    lat_fixed = 3;
    do_reset(0);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    repeat (8) step();
    for (int i = 1; i < 8; i++) chk1("rd_no_valid", t_valid[i], 1'b0);
    chk1("rd_req3", t_req[3], 1'b0);
    chk1("rd_req4", t_req[4], 1'b1);    chk("rd_addr4", t_addr[4], 32'h0000_0100);
    chk1("rd_valid8", t_valid[8], 1'b1); chk("rd_pc8", t_pc[8], 32'h0000_0100);

    // Redirect coinciding with a response and a pop
    lat_fixed = 1;
    do_reset(0);
    repeat (2) step();
    stall = 1'b1;
    step();
    stall = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    repeat (4) step();
    chk1("rp_valid3", t_valid[3], 1'b1); chk("rp_pc3", t_pc[3], 32'h0);
    chk1("rp_valid4", t_valid[4], 1'b0);
    chk1("rp_req4", t_req[4], 1'b1);    chk("rp_addr4", t_addr[4], 32'h0000_0040);
    chk("rp_pc6", t_pc[6], 32'h0000_0040);

    // Asynchronous reset while draining a stale response
    lat_fixed = 3;
    do_reset(0);
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    #2;
    reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = JUNK;
    #1;
    chk1("ar_valid", if_valid, 1'b0);
    chk("ar_pc", if_pc, 32'h0);
    chk("ar_instr", if_instr, NOP);
    chk("ar_addr", imem_addr, 32'h0);
    lat_fixed = 1;
    do_reset(1);
    repeat (4) step();
    chk1("ar_req0", t_req[0], 1'b1);    chk("ar_addr0", t_addr[0], 32'h0);
    chk1("ar_valid1", t_valid[1], 1'b0);
    chk("ar_pc2", t_pc[2], 32'h0);      chk("ar_instr2", t_instr[2], 32'h1357_9BDF);

    // Randomized traffic: stalls, redirects, variable latency, spurious responses
    lat_fixed = 0;
    do_reset(0);
    rand_mode = 1;
    spurious_en = 1;
    repeat (3000) step();
    rand_mode = 0;
    spurious_en = 0;
    stall = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
